lms_coeff_update: RTL and testbench

LMS adaptation engine for the fractionally spaced equalizer. It consumes the transposed FIR output `y` and the same T/2-spaced input stream `x`, computes a PAM2 decision-directed error once per symbol (every second clock), and updates `Ncoeff` high-precision tap accumulators. Their truncated values drive the FIR's packed `coeff` bus, closing the adaptation loop.

---
 rtl/fse_lms_pkg.sv | 22 ++
 rtl/lms_tap_acc.sv | 56 +++++
 rtl/lms_coeff_update.sv | 130 +++++++++++++
 tb/tb_lms_coeff_update.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fse_lms_pkg.sv
// Shared definitions for the fractionally spaced equalizer and its LMS adaptation engine.
// Holds the pipeline alignment, slicer scaling, FSM encodings and tap packing helper.
package fse_lms_pkg;

    // FIR output y(t) lags the input sample feeding tap 0 by this many clocks
    localparam int LAT = 2;

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_ADAPT  = 2'd1;
    localparam logic [1:0] ST_FREEZE = 2'd2;

    // +1.0 in a fixed-point format with nbf fractional bits; -1.0 is its negation
    function automatic int slicer_one(input int nbf);
        return 1 << nbf;
    endfunction

    // MSB index of tap i in a packed coefficient bus of nb-bit taps
    function automatic int tap_hi(input int i, input int nb);
        return nb * (i + 1) - 1;
    endfunction

endpackage

// File: rtl/lms_tap_acc.sv
// One LMS tap: acc <= sat(acc + ((e*regressor) <<< ALIGN) >>> shift) when upd is high.
// Registered output, one cycle from upd to coeff; no backpressure.
module lms_tap_acc #(
    parameter int NBe     = 9,
    parameter int NBx     = 8,
    parameter int NBacc   = 16,
    parameter int NBcoeff = 7,
    parameter int ALIGN   = 4,
    parameter int NBsh    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [NBe-1:0]     e,
    input  logic signed [NBx-1:0]     regressor,
    input  logic        [NBsh-1:0]    shift,
    input  logic                      upd,
    input  logic        [NBacc-1:0]   init,
    output logic        [NBcoeff-1:0] coeff
);

    localparam int PW = NBe + NBx;
    localparam int AW = PW + ALIGN;
    // one guard bit above the wider of term and acc so the sum can never wrap
    localparam int SW = ((AW > NBacc) ? AW : NBacc) + 1;

    localparam logic signed [SW-1:0] ACC_MAX = {{(SW-NBacc+1){1'b0}}, {(NBacc-1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {{(SW-NBacc+1){1'b1}}, {(NBacc-1){1'b0}}};

    logic signed [NBacc-1:0] acc;
    logic signed [PW-1:0]    prod;
    logic signed [AW-1:0]    term;
    logic signed [SW-1:0]    sum;

    always_comb begin
        prod = PW'(e) * PW'(regressor);
        term = (AW'(prod) <<< ALIGN) >>> shift;
        sum  = SW'(acc) + SW'(term);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= init;
        end else if (upd) begin
            if (sum > ACC_MAX) begin
                acc <= ACC_MAX[NBacc-1:0];
            end else if (sum < ACC_MIN) begin
                acc <= ACC_MIN[NBacc-1:0];
            end else begin
                acc <= sum[NBacc-1:0];
            end
        end
    end

    assign coeff = acc[NBacc-1 -: NBcoeff];

endmodule

// File: rtl/lms_coeff_update.sv
// Decision-directed PAM2 LMS engine: one update per symbol (every second clock) over Ncoeff taps.
// coeff and err are registered one edge after the symbol cycle; enable low freezes taps, no backpressure.
module lms_coeff_update
    import fse_lms_pkg::*;
#(
    parameter int NBin     = 8,
    parameter int NBFin    = 5,
    parameter int NBy      = 8,
    parameter int NBFy     = 5,
    parameter int Ncoeff   = 9,
    parameter int NBcoeff  = 7,
    parameter int NBFcoeff = 5,
    parameter int NBacc    = 16,
    parameter int NBFacc   = 14,
    parameter int MU_SHIFT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [NBin-1:0]      x,
    input  logic signed [NBy-1:0]       y,
    input  logic                        enable,
    input  logic        [1:0]           mu_sel,
    input  logic                        phase_sel,
    output logic [Ncoeff*NBcoeff-1:0]   coeff,
    output logic signed [NBy:0]         err,
    output logic                        adapting
);

    if (NBacc - NBFacc != NBcoeff - NBFcoeff) begin : g_bad_fmt
        $error("accumulator and coefficient integer widths differ");
    end

    // dline[k] holds x(t-1-k), so tap m's regressor x(t-LAT-m) sits at dline[LAT+m-1]
    localparam int NDL   = Ncoeff + LAT - 1;
    localparam int FILL  = Ncoeff + LAT;
    localparam int CW    = $clog2(FILL + 1);
    localparam int ALIGN = NBFacc - NBFy - NBFin;
    localparam int ONE_Y = slicer_one(NBFy);
    localparam int ONE_A = slicer_one(NBFacc);

    localparam logic signed [NBy:0] D_POS = (NBy+1)'(ONE_Y);
    localparam logic signed [NBy:0] D_NEG = -D_POS;

    logic signed [NBin-1:0] dline [NDL];
    logic                   phase;
    logic [1:0]             state;
    logic [CW-1:0]          fill_cnt;
    logic                   sym;
    logic                   upd;
    logic signed [NBy:0]    y_ext;
    logic signed [NBy:0]    d;
    logic signed [NBy:0]    e;
    logic [3:0]             shift;

    assign sym   = (phase == phase_sel);
    assign upd   = (state == ST_ADAPT) && sym && enable;
    assign y_ext = {y[NBy-1], y};
    assign d     = y[NBy-1] ? D_NEG : D_POS;
    assign e     = d - y_ext;
    assign shift = 4'(MU_SHIFT) + 4'(mu_sel);

    assign adapting = (state == ST_ADAPT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase    <= 1'b0;
            state    <= ST_FILL;
            fill_cnt <= '0;
            err      <= '0;
            for (int i = 0; i < NDL; i++) begin
                dline[i] <= '0;
            end
        end else begin
            phase    <= ~phase;
            dline[0] <= x;
            for (int i = 1; i < NDL; i++) begin
                dline[i] <= dline[i-1];
            end

            case (state)
                ST_FILL: begin
                    if (fill_cnt == CW'(FILL - 1)) begin
                        state <= enable ? ST_ADAPT : ST_FREEZE;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                ST_ADAPT: begin
                    if (!enable) begin
                        state <= ST_FREEZE;
                    end
                end
                ST_FREEZE: begin
                    if (enable) begin
                        state <= ST_ADAPT;
                    end
                end
                default: state <= ST_FILL;
            endcase

            // err stays at its reset value of 0 throughout FILL
            if (state != ST_FILL && sym) begin
                err <= e;
            end
        end
    end

    for (genvar m = 0; m < Ncoeff; m++) begin : g_tap
        localparam logic [NBacc-1:0] INIT = (m == Ncoeff / 2) ? NBacc'(ONE_A) : '0;

        lms_tap_acc #(
            .NBe     (NBy + 1),
            .NBx     (NBin),
            .NBacc   (NBacc),
            .NBcoeff (NBcoeff),
            .ALIGN   (ALIGN),
            .NBsh    (4)
        ) u_tap (
            .clk       (clk),
            .reset     (reset),
            .e         (e),
            .regressor (dline[LAT + m - 1]),
            .shift     (shift),
            .upd       (upd),
            .init      (INIT),
            .coeff     (coeff[tap_hi(m, NBcoeff) -: NBcoeff])
        );
    end

endmodule

// File: tb/tb_lms_coeff_update.sv
// Bench for lms_coeff_update: table-driven single updates checked against a small accumulator model,
// plus hand sequences for fill timing, decimation, freeze, saturation and mid-run reset.
module tb_lms_coeff_update;

    localparam int NC  = 9;
    localparam int NBC = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  x = 8'h00;
    logic [7:0]  y = 8'h00;
    logic        enable = 1'b0;
    logic [1:0]  mu_sel = 2'd0;
    logic        phase_sel = 1'b0;
    logic [62:0] coeff;
    logic [8:0]  err;
    logic        adapting;

    lms_coeff_update dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .enable    (enable),
        .mu_sel    (mu_sel),
        .phase_sel (phase_sel),
        .coeff     (coeff),
        .err       (err),
        .adapting  (adapting)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int k = 0;              // edges since reset release; phase == k % 2
    int macc [NC];
    logic [62:0] sbq [$];

    typedef struct {
        logic [7:0] vx;
        logic [7:0] vy;
        logic [1:0] mu;
        logic [8:0] e;
        int         delta;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) k++;
        else k = 0;
        #1;
    endtask

    function automatic bit sym();
        return (k % 2) == int'(phase_sel);
    endfunction

    task automatic model_init();
        for (int i = 0; i < NC; i++) macc[i] = 0;
        macc[NC/2] = 16384;
    endtask

    task automatic model_set(input int v);
        for (int i = 0; i < NC; i++) macc[i] = v;
    endtask

    task automatic model_add(input int delta);
        for (int i = 0; i < NC; i++) begin
            macc[i] = macc[i] + delta;
            if (macc[i] > 32767) macc[i] = 32767;
            else if (macc[i] < -32768) macc[i] = -32768;
        end
    endtask

    function automatic logic [62:0] model_bus();
        logic [62:0] b;
        int c;
        b = '0;
        for (int i = 0; i < NC; i++) begin
            c = macc[i] >>> 9;
            b[i*NBC +: NBC] = c[6:0];
        end
        return b;
    endfunction

    task automatic expect_add(input int delta);
        model_add(delta);
        sbq.push_back(model_bus());
    endtask

    task automatic chk_sb(input string name);
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, got %h", name, coeff);
        end else begin
            chk(name, coeff, sbq.pop_front());
        end
    endtask

    task automatic wait_adapt(input string name);
        int n = 0;
        while (!adapting && n < 30) begin
            tick();
            n++;
        end
        chk(name, n, 11);
    endtask

    // From FREEZE: enter ADAPT on a non-symbol cycle, take exactly one symbol update, drop back
    task automatic one_update(input int delta);
        if (sym()) tick();
        enable = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        tick();
        expect_add(delta);
    endtask

    initial begin
        logic [62:0] prev;
        int changes;
        bit s;

        vecs[0] = '{8'h20, 8'h10, 2'd0, 9'h010, 512};
        vecs[1] = '{8'h20, 8'hF0, 2'd0, 9'h1F0, -512};
        vecs[2] = '{8'hE0, 8'h00, 2'd1, 9'h020, -512};
        vecs[3] = '{8'h15, 8'h3A, 2'd2, 9'h1E6, -137};
        vecs[4] = '{8'h81, 8'hC7, 2'd3, 9'h019, -397};
        vecs[5] = '{8'h7F, 8'h7F, 2'd3, 9'h1A1, -1509};

        // reset state
        x = 8'h20; y = 8'h10;
        repeat (3) tick();
        model_init();
        chk("rst_coeff", coeff, model_bus());
        chk("rst_tap4", coeff[34:28], 7'h20);
        chk("rst_err", err, 0);
        chk("rst_adapting", adapting, 0);

        reset = 1'b1; enable = 1'b1;
        wait_adapt("fill_len");
        chk("adapt_entry_coeff", coeff, model_bus());
        tick();
        chk("nonsym_hold", coeff, model_bus());
        tick();
        expect_add(512);
        chk_sb("first_upd");
        chk("first_upd_tap4", coeff[34:28], 7'h21);
        chk("first_err", err, 9'h010);

        // decimation: 20 cycles in ADAPT give 10 updates
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            prev = coeff;
            tick();
            if (coeff !== prev) changes++;
        end
        chk("decim_count", changes, 10);
        for (int i = 0; i < 10; i++) model_add(512);
        sbq.push_back(model_bus());
        chk_sb("decim_coeff");

        // updates follow phase_sel to the other parity
        phase_sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s = sym();
            prev = coeff;
            tick();
            chk("phase_flip_upd", coeff !== prev, s);
            if (s) model_add(512);
        end
        chk("phase_flip_coeff", coeff, model_bus());
        phase_sel = 1'b0;

        // freeze, with enable dropping on a symbol cycle
        if (!sym()) tick();
        y = 8'hF0; enable = 1'b0;
        repeat (50) tick();
        chk("freeze_coeff", coeff, model_bus());
        chk("freeze_adapting", adapting, 0);
        chk("freeze_err", err, 9'h1F0);
        y = 8'h08;
        tick(); tick();
        chk("freeze_err2", err, 9'h018);
        chk("freeze_coeff2", coeff, model_bus());

        // table of single updates
        for (int v = 0; v < 6; v++) begin
            x = vecs[v].vx; y = vecs[v].vy; mu_sel = vecs[v].mu;
            repeat (12) tick();
            chk($sformatf("vec%0d_err", v), err, vecs[v].e);
            chk($sformatf("vec%0d_hold", v), coeff, model_bus());
            one_update(vecs[v].delta);
            chk_sb($sformatf("vec%0d_upd", v));
        end

        // saturation at both rails, then recovery off the rail
        x = 8'h7F; y = 8'h80; mu_sel = 2'd0; enable = 1'b1;
        repeat (400) tick();
        model_set(32767);
        chk("sat_pos", coeff, model_bus());
        chk("sat_pos_tap4", coeff[34:28], 7'h3F);
        chk("sat_err", err, 9'h060);
        chk("sat_adapting", adapting, 1);
        x = 8'h81;
        repeat (400) tick();
        model_set(-32768);
        chk("sat_neg", coeff, model_bus());
        chk("sat_neg_tap0", coeff[6:0], 7'h40);
        enable = 1'b0; x = 8'h20; y = 8'h10;
        repeat (12) tick();
        one_update(512);
        chk_sb("sat_release");
        chk("sat_release_tap0", coeff[6:0], 7'h41);

        // reset in the middle of ADAPT
        enable = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_init();
        chk("midrst_coeff", coeff, model_bus());
        chk("midrst_adapting", adapting, 0);
        chk("midrst_err", err, 0);
        wait_adapt("refill_len");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
